// File: rtl/matrix_result_writer.sv
`default_nettype none
// ============================================================================
// Module   : matrix_result_writer
// Purpose  : Writes a 3-word header plus row-major elements of one matrix into
//            its BRAM slot and tracks which slots hold a complete matrix.
// Revision : 1.0 - initial release
// ============================================================================
module matrix_result_writer #(
    parameter int BLOCK_SIZE   = 1152,
    parameter int ADDR_WIDTH   = 14,
    parameter int DATA_WIDTH   = 32,
    parameter int HEADER_WORDS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  write_request,
    output logic                  write_ready,
    input  logic [2:0]            write_matrix_id,
    input  logic [7:0]            write_rows,
    input  logic [7:0]            write_cols,
    input  logic [0:7][7:0]       write_name,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  write_data_valid,
    output logic                  writer_ready,
    output logic                  write_done,
    output logic                  write_error,
    output logic                  bram_wr_en,
    output logic [ADDR_WIDTH-1:0] bram_wr_addr,
    output logic [DATA_WIDTH-1:0] bram_wr_data,
    output logic [7:0]            matrix_valid
);

    localparam logic [ADDR_WIDTH-1:0] c_BLOCK     = ADDR_WIDTH'(BLOCK_SIZE);
    localparam logic [ADDR_WIDTH-1:0] c_HDR_WORDS = ADDR_WIDTH'(HEADER_WORDS);
    localparam logic [15:0]           c_MAX_TOTAL = 16'(BLOCK_SIZE - HEADER_WORDS);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CHECK  = 3'd1,
        S_HDR0   = 3'd2,
        S_HDR1   = 3'd3,
        S_HDR2   = 3'd4,
        S_STREAM = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    state_t                  state_q, state_d;
    logic [2:0]              id_q, id_d;
    logic [7:0]              rows_q, rows_d;
    logic [7:0]              cols_q, cols_d;
    logic [0:7][7:0]         name_q, name_d;
    logic [15:0]             total_q, total_d;
    logic [15:0]             count_q, count_d;
    logic [ADDR_WIDTH-1:0]   base_q, base_d;
    logic                    err_q, err_d;
    logic                    write_ready_q, write_ready_d;
    logic                    writer_ready_q, writer_ready_d;
    logic                    write_done_q, write_done_d;
    logic                    write_error_q, write_error_d;
    logic                    wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
    logic [7:0]              valid_q, valid_d;
    logic                    w_reject;

    assign w_reject = (rows_q == 8'd0) || (cols_q == 8'd0) || (total_q > c_MAX_TOTAL);

    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        rows_d    = rows_q;
        cols_d    = cols_q;
        name_d    = name_q;
        total_d   = total_q;
        count_d   = count_q;
        base_d    = base_q;
        err_d     = err_q;
        valid_d   = valid_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        case (state_q)
            S_IDLE: begin
                if (write_request) begin
                    id_d    = write_matrix_id;
                    rows_d  = write_rows;
                    cols_d  = write_cols;
                    name_d  = write_name;
                    total_d = 16'(write_rows) * 16'(write_cols);
                    base_d  = ADDR_WIDTH'(write_matrix_id) * c_BLOCK;
                    count_d = 16'd0;
                    err_d   = 1'b0;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (w_reject) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    valid_d[id_q] = 1'b0;
                    wr_en_d       = 1'b1;
                    wr_addr_d     = base_q;
                    wr_data_d     = DATA_WIDTH'({rows_q, cols_q});
                    state_d       = S_HDR0;
                end
            end
            S_HDR0: begin
                wr_en_d   = 1'b1;
                wr_addr_d = base_q + ADDR_WIDTH'(1);
                wr_data_d = DATA_WIDTH'({name_q[3], name_q[2], name_q[1], name_q[0]});
                state_d   = S_HDR1;
            end
            S_HDR1: begin
                wr_en_d   = 1'b1;
                wr_addr_d = base_q + ADDR_WIDTH'(2);
                wr_data_d = DATA_WIDTH'({name_q[7], name_q[6], name_q[5], name_q[4]});
                state_d   = S_HDR2;
            end
            S_HDR2: begin
                state_d = S_STREAM;
            end
            S_STREAM: begin
                if (write_data_valid) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = base_q + c_HDR_WORDS + ADDR_WIDTH'(count_q);
                    wr_data_d = write_data;
                    count_d   = count_q + 16'd1;
                    if (count_q == total_q - 16'd1) begin
                        valid_d[id_q] = 1'b1;
                        state_d       = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Handshake outputs are registered copies of the next state.
        write_ready_d  = (state_d == S_IDLE);
        writer_ready_d = (state_d == S_STREAM);
        write_done_d   = (state_d == S_DONE);
        write_error_d  = (state_d == S_DONE) && err_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            id_q           <= 3'd0;
            rows_q         <= 8'd0;
            cols_q         <= 8'd0;
            name_q         <= '0;
            total_q        <= 16'd0;
            count_q        <= 16'd0;
            base_q         <= '0;
            err_q          <= 1'b0;
            write_ready_q  <= 1'b1;
            writer_ready_q <= 1'b0;
            write_done_q   <= 1'b0;
            write_error_q  <= 1'b0;
            wr_en_q        <= 1'b0;
            wr_addr_q      <= '0;
            wr_data_q      <= '0;
            valid_q        <= 8'd0;
        end else begin
            state_q        <= state_d;
            id_q           <= id_d;
            rows_q         <= rows_d;
            cols_q         <= cols_d;
            name_q         <= name_d;
            total_q        <= total_d;
            count_q        <= count_d;
            base_q         <= base_d;
            err_q          <= err_d;
            write_ready_q  <= write_ready_d;
            writer_ready_q <= writer_ready_d;
            write_done_q   <= write_done_d;
            write_error_q  <= write_error_d;
            wr_en_q        <= wr_en_d;
            wr_addr_q      <= wr_addr_d;
            wr_data_q      <= wr_data_d;
            valid_q        <= valid_d;
        end
    end

    assign write_ready  = write_ready_q;
    assign writer_ready = writer_ready_q;
    assign write_done   = write_done_q;
    assign write_error  = write_error_q;
    assign bram_wr_en   = wr_en_q;
    assign bram_wr_addr = wr_addr_q;
    assign bram_wr_data = wr_data_q;
    assign matrix_valid = valid_q;

endmodule
`default_nettype wire

// File: doc/matrix_result_writer.md
Name: matrix_result_writer

Overview:
Storage-manager write engine directly downstream of the matrix operation executor. It accepts one matrix per transaction over the request/ready/valid/done handshake, and writes a 3-word header plus row-major element data into the matrix BRAM slot selected by the matrix ID. It also keeps a per-slot valid bitmap for the read side.

Parameters:
BLOCK_SIZE, MATRIX_BLOCK_SIZE (package), words per matrix slot; slot base = id*BLOCK_SIZE.
ADDR_WIDTH, MATRIX_ADDR_WIDTH (package), BRAM address width.
DATA_WIDTH, MATRIX_DATA_WIDTH (package), element width; must be >= 32.
HEADER_WORDS, 3, header words preceding data in each slot.

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
write_request  in  1  requester holds high until writer_ready is seen
write_ready  out  1  engine idle, request may be issued
write_matrix_id  in  3  destination slot 0..7
write_rows  in  8  row count
write_cols  in  8  column count
write_name  in  8x[0:7]  8-byte ASCII name, byte 0 first
write_data  in  DATA_WIDTH  element data
write_data_valid  in  1  element beat strobe
writer_ready  out  1  engine accepting element beats
write_done  out  1  one-cycle completion pulse
write_error  out  1  one-cycle pulse with write_done on rejected request
bram_wr_en  out  1  BRAM write enable
bram_wr_addr  out  ADDR_WIDTH  BRAM write address
bram_wr_data  out  DATA_WIDTH  BRAM write data
matrix_valid  out  8  bit i set = slot i holds a complete matrix

Behaviour:
- Clocking: one clock, clk. Reset: asynchronous, active-low, rst_n. All state is in clk flops.
- Reset values: state IDLE, write_ready=1, writer_ready=0, write_done=0, write_error=0, bram_wr_en=0, bram_wr_addr=0, bram_wr_data=0, matrix_valid=0, counters 0.
- Reset mid-transaction aborts immediately. No further BRAM writes occur, and the partial slot stays invalid.
- State machine:
  - IDLE --(write_request)--> CHECK
  - CHECK --(reject)--> DONE
  - CHECK --(accept)--> HDR0 -> HDR1 -> HDR2 -> STREAM
  - STREAM --(last beat)--> DONE
  - DONE -> IDLE
- write_ready = (state==IDLE), registered.
- IDLE: on write_request=1, latch id, rows, cols, name[0:7]. Compute total = rows*cols as 16-bit. Compute base = id*BLOCK_SIZE.
- CHECK: reject if rows==0, cols==0, or total+HEADER_WORDS > BLOCK_SIZE.
  - On reject: go to DONE with the error flag set. No BRAM writes, and matrix_valid is unchanged.
  - On accept: clear matrix_valid[id] in the same cycle.
- Header writes, one per cycle with bram_wr_en=1:
  - HDR0: address base+0, data {zeros, rows[15:8], cols[7:0]}.
  - HDR1: address base+1, data {name[3],name[2],name[1],name[0]}, with name[0] in bits 7:0.
  - HDR2: address base+2, data {name[7..4]}, same packing. Upper bits above 32 are zero.
- STREAM: writer_ready=1, registered and asserted from the first STREAM cycle.
  - Each cycle with write_data_valid=1 writes write_data to base+HEADER_WORDS+count, then count increments.
  - Beats are accepted back-to-back at one per cycle, or with arbitrary gaps.
  - bram_wr_* are registered: the write appears one cycle after the beat is sampled.
- Last beat: the beat with count==total-1 moves the state to DONE and deasserts writer_ready the next cycle.
- DONE: write_done=1 for exactly one cycle and write_error = error flag.
  - On success, matrix_valid[id] is set in this cycle.
  - The next state is IDLE, where write_ready returns to 1.
- Ignored inputs:
  - write_data_valid outside STREAM.
  - write_request outside IDLE. A request still held in DONE is not re-sampled until IDLE.
- Latency: request sampled in cycle 0, CHECK in cycle 1, header in cycles 2-4, writer_ready=1 from cycle 5. write_done comes 1 cycle after the last beat is sampled.
- No backpressure within STREAM: writer_ready stays high until all total beats are taken.
- Address arithmetic: no wrap-around, guaranteed by the CHECK bound.
- Element data is written verbatim, with no sign or width conversion.

Test Plan:
- 2x3 "MATA" to id 1 (BLOCK_SIZE=1152), beats 1..6 back-to-back:
  - Header at 1152..1154: word 1152=0x0203, word 1153=0x4154414D.
  - Data 1..6 at 1155..1160.
  - One write_done pulse, matrix_valid=0x02.
- 1x1 "SCALAR" to id 7, single valid pulse of 0xDEADBEEF on the second writer_ready cycle:
  - Data word at 7*1152+3.
  - Header word 1=0x4C414353, word 2=0x00005241.
  - matrix_valid[7]=1.
- Gapped stream 3x3, valid every third cycle:
  - Exactly 9 data writes at consecutive addresses.
  - Valid asserted in IDLE/HDR cycles beforehand causes no writes.
- Reject rows=0, and separately 40x40 (1603 > 1152):
  - write_done and write_error pulse together 2 cycles after the request.
  - Zero bram_wr_en, writer_ready never high, matrix_valid unchanged.
- Overwrite id 1 (valid) and assert rst_n=0 after 2 of 4 beats:
  - After reset: all outputs at reset values, matrix_valid=0, write_ready=1.
  - A fresh 1x1 request then completes normally.
- Back-to-back: second request held high through DONE is accepted only from IDLE. write_ready is low in DONE, and the second header starts 2 cycles after IDLE.
